// File: rtl/if_fetch_ctrl_if.sv
// Instruction-memory fetch handshake between the fetch controller and imem.
// The controller drives req/addr; memory answers with ack/rdata.
interface if_fetch_ctrl_if #(
    parameter int ADDR_W = 32
) ();
    logic              req;
    logic [ADDR_W-1:0] addr;
    logic              ack;
    logic [31:0]       rdata;

    modport master (
        output req,
        output addr,
        input  ack,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output ack,
        output rdata
    );
endinterface

// File: rtl/if_fetch_ctrl.sv
// Fetch controller: owns the PC, sequences imem fetches, builds the stall
// vector and drives the IF/ID register.
module if_fetch_ctrl #(
    parameter int              ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int              NSTG     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NSTG-1:0]   stall_req,
    input  logic              branch_flag,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              flush,
    input  logic [ADDR_W-1:0] flush_pc,
    if_fetch_ctrl_if.master   imem,
    output logic [ADDR_W-1:0] pc,
    output logic [NSTG+1:0]   stall_o,
    output logic [31:0]       inst_o,
    output logic [ADDR_W-1:0] inst_pc_o,
    output logic              inst_valid_o
);

    typedef enum logic [1:0] {
        BOOT,
        FETCH,
        HOLD
    } state_t;

    state_t            state;
    logic              pbuf_valid;
    logic [31:0]       pbuf_inst;
    logic [ADDR_W-1:0] pbuf_pc;
    logic              discard;
    logic [ADDR_W-1:0] rdr_pc;

    logic [NSTG-1:0]   th;
    logic              redirect;
    logic [ADDR_W-1:0] target;
    logic              hold_ifid;

    // th[k] = some stage at or beyond k requests a stall
    always_comb begin
        th = '0;
        for (int j = 0; j < NSTG; j++) begin
            th[j] = |(stall_req >> j);
        end
    end

    assign stall_o   = flush ? '0 : {th, th[0], th[0]};
    assign hold_ifid = stall_o[1];
    assign redirect  = flush | branch_flag;
    assign target    = flush ? flush_pc : branch_target;

    assign imem.req  = (state == FETCH);
    assign imem.addr = pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= BOOT;
            pc           <= RESET_PC;
            inst_o       <= '0;
            inst_pc_o    <= '0;
            inst_valid_o <= 1'b0;
            pbuf_valid   <= 1'b0;
            pbuf_inst    <= '0;
            pbuf_pc      <= '0;
            discard      <= 1'b0;
            rdr_pc       <= '0;
        end else if (redirect) begin
            inst_valid_o <= 1'b0;
            pbuf_valid   <= 1'b0;
            if (state != FETCH || imem.ack) begin
                pc      <= target;
                state   <= FETCH;
                discard <= 1'b0;
            end else begin
                // request in flight: keep addr stable, retarget on its ack
                rdr_pc  <= target;
                discard <= 1'b1;
            end
        end else begin
            unique case (state)
                BOOT: begin
                    state <= FETCH;
                    if (!hold_ifid) inst_valid_o <= 1'b0;
                end
                FETCH: begin
                    if (imem.ack && discard) begin
                        pc      <= rdr_pc;
                        discard <= 1'b0;
                        if (!hold_ifid) inst_valid_o <= 1'b0;
                    end else if (imem.ack) begin
                        pc <= pc + ADDR_W'(4);
                        if (!hold_ifid) begin
                            inst_o       <= imem.rdata;
                            inst_pc_o    <= pc;
                            inst_valid_o <= 1'b1;
                        end else begin
                            pbuf_inst  <= imem.rdata;
                            pbuf_pc    <= pc;
                            pbuf_valid <= 1'b1;
                            state      <= HOLD;
                        end
                    end else if (!hold_ifid) begin
                        inst_valid_o <= 1'b0;
                    end
                end
                HOLD: begin
                    if (!hold_ifid) begin
                        inst_o       <= pbuf_inst;
                        inst_pc_o    <= pbuf_pc;
                        inst_valid_o <= 1'b1;
                        pbuf_valid   <= 1'b0;
                        state        <= FETCH;
                    end
                end
                default: state <= BOOT;
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Bench for if_fetch_ctrl: wait-state memory model plus an IF/ID scoreboard.
module tb_if_fetch_ctrl;

    logic        clk;
    logic        rst;
    logic [3:0]  stall_req;
    logic        branch_flag;
    logic [31:0] branch_target;
    logic        flush;
    logic [31:0] flush_pc;
    logic [31:0] pc;
    logic [5:0]  stall_o;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        inst_valid_o;

    int total = 0;
    int bad   = 0;
    int waits = 0;
    int cnt   = 0;

    logic [63:0] expq[$];
    logic        tb_disc = 1'b0;
    logic        st1_at_edge = 1'b0;

    if_fetch_ctrl_if #(.ADDR_W(32)) m ();

    if_fetch_ctrl #(
        .ADDR_W(32),
        .RESET_PC(32'h0),
        .NSTG(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .stall_req(stall_req),
        .branch_flag(branch_flag),
        .branch_target(branch_target),
        .flush(flush),
        .flush_pc(flush_pc),
        .imem(m.master),
        .pc(pc),
        .stall_o(stall_o),
        .inst_o(inst_o),
        .inst_pc_o(inst_pc_o),
        .inst_valid_o(inst_valid_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // memory with programmable wait states; data is a fixed function of addr
    assign m.ack   = m.req && (cnt == waits);
    assign m.rdata = m.addr ^ 32'h1357_9BDF;

    always @(posedge clk) begin
        if (!m.req || m.ack) cnt <= 0;
        else cnt <= cnt + 1;
    end

    // scoreboard producer: accepted acks, dropped on redirect or reset
    always @(posedge clk) begin
        st1_at_edge = stall_o[1];
        if (rst) begin
            expq.delete();
            tb_disc = 1'b0;
        end else if (flush || branch_flag) begin
            expq.delete();
            tb_disc = m.req && !m.ack;
        end else if (m.req && m.ack) begin
            if (!tb_disc) expq.push_back({m.addr, m.rdata});
            tb_disc = 1'b0;
        end
    end

    // scoreboard consumer: one pop per new IF/ID delivery
    always @(negedge clk) begin
        if (!rst && inst_valid_o && !st1_at_edge) begin
            total++;
            if (expq.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected pc=%h inst=%h", inst_pc_o, inst_o);
            end else begin
                logic [63:0] e;
                e = expq.pop_front();
                if ({inst_pc_o, inst_o} !== e) begin
                    bad++;
                    $display("FAIL sb_data got=%h/%h exp=%h/%h",
                             inst_pc_o, inst_o, e[63:32], e[31:0]);
                end
            end
        end
    end

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic do_reset;
        rst = 1'b1;
        stall_req = '0;
        flush = 1'b0;
        branch_flag = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        waits = 0;
        rst = 1'b1;
        stall_req = '0;
        flush = 1'b0;
        branch_flag = 1'b0;
        tick();
        tick();
        total++;
        if ({pc, m.req, inst_valid_o, inst_o, inst_pc_o} !== {32'h0, 1'b0, 1'b0, 32'h0, 32'h0}) begin
            bad++;
            $display("FAIL rst_vals pc=%h req=%b v=%b i=%h ip=%h exp 0", pc, m.req, inst_valid_o, inst_o, inst_pc_o);
        end
        rst = 1'b0;
        #1;
        total++;
        if (m.req !== 1'b0) begin
            bad++;
            $display("FAIL boot_req got=%b exp=0", m.req);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (m.req !== 1'b1 || m.addr !== 32'(i * 4)) begin
                bad++;
                $display("FAIL seq_addr%0d got=%h req=%b exp=%h", i, m.addr, m.req, 32'(i * 4));
            end
            total++;
            if (inst_valid_o !== (i > 0)) begin
                bad++;
                $display("FAIL seq_valid%0d got=%b exp=%b", i, inst_valid_o, i > 0);
            end
        end
    endtask

    task automatic test_wait_states;
        waits = 3;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            tick();
            if (i < 4) begin
                total++;
                if (m.addr !== 32'h0 || m.req !== 1'b1) begin
                    bad++;
                    $display("FAIL ws_hold%0d addr=%h req=%b exp=0/1", i, m.addr, m.req);
                end
            end
            total++;
            if (inst_valid_o !== (i == 4 || i == 8)) begin
                bad++;
                $display("FAIL ws_valid%0d got=%b exp=%b", i, inst_valid_o, i == 4 || i == 8);
            end
        end
    endtask

    task automatic test_stall;
        waits = 0;
        do_reset();
        tick();
        tick();
        tick();
        total++;
        if (m.addr !== 32'h8 || inst_pc_o !== 32'h4) begin
            bad++;
            $display("FAIL st_pre addr=%h ip=%h exp=8/4", m.addr, inst_pc_o);
        end
        stall_req = 4'b0010;
        #1;
        total++;
        if (stall_o !== 6'b001111) begin
            bad++;
            $display("FAIL st_vec got=%b exp=001111", stall_o);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            total++;
            if (m.req !== 1'b0 || inst_pc_o !== 32'h4 || inst_valid_o !== 1'b1) begin
                bad++;
                $display("FAIL st_hold%0d req=%b ip=%h v=%b exp=0/4/1", i, m.req, inst_pc_o, inst_valid_o);
            end
        end
        tick();
        stall_req = '0;
        tick();
        total++;
        if (inst_pc_o !== 32'h8 || inst_valid_o !== 1'b1 || m.req !== 1'b1 || m.addr !== 32'hC) begin
            bad++;
            $display("FAIL st_rel ip=%h v=%b req=%b addr=%h exp=8/1/1/c", inst_pc_o, inst_valid_o, m.req, m.addr);
        end
    endtask

    task automatic test_branch;
        waits = 0;
        do_reset();
        for (int i = 0; i < 20 && m.addr !== 32'h10; i++) tick();
        total++;
        if (m.addr !== 32'h10) begin
            bad++;
            $display("FAIL br_reach addr=%h exp=10", m.addr);
        end
        waits = 3;
        branch_flag = 1'b1;
        branch_target = 32'h100;
        tick();
        branch_flag = 1'b0;
        total++;
        if (m.req !== 1'b1 || m.addr !== 32'h10) begin
            bad++;
            $display("FAIL br_stable req=%b addr=%h exp=1/10", m.req, m.addr);
        end
        for (int i = 0; i < 10 && m.addr === 32'h10; i++) tick();
        total++;
        if (m.addr !== 32'h100 || inst_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL br_redir addr=%h v=%b exp=100/0", m.addr, inst_valid_o);
        end
        waits = 0;
        tick();
        total++;
        if (inst_pc_o !== 32'h100 || inst_valid_o !== 1'b1) begin
            bad++;
            $display("FAIL br_deliv ip=%h v=%b exp=100/1", inst_pc_o, inst_valid_o);
        end
    endtask

    task automatic test_flush;
        waits = 0;
        do_reset();
        tick();
        tick();
        stall_req = 4'b0001;
        tick();
        total++;
        if (m.req !== 1'b0) begin
            bad++;
            $display("FAIL fl_park req=%b exp=0", m.req);
        end
        flush = 1'b1;
        flush_pc = 32'h180;
        branch_flag = 1'b1;
        branch_target = 32'h100;
        #1;
        total++;
        if (stall_o !== 6'b0) begin
            bad++;
            $display("FAIL fl_vec got=%b exp=000000", stall_o);
        end
        tick();
        flush = 1'b0;
        branch_flag = 1'b0;
        total++;
        if (pc !== 32'h180 || inst_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL fl_pc pc=%h v=%b exp=180/0", pc, inst_valid_o);
        end
        tick();
        stall_req = '0;
        tick();
        total++;
        if (inst_pc_o !== 32'h180 || inst_valid_o !== 1'b1) begin
            bad++;
            $display("FAIL fl_deliv ip=%h v=%b exp=180/1", inst_pc_o, inst_valid_o);
        end
    endtask

    task automatic test_wrap;
        waits = 0;
        do_reset();
        tick();
        branch_flag = 1'b1;
        branch_target = 32'hFFFF_FFFC;
        tick();
        branch_flag = 1'b0;
        total++;
        if (pc !== 32'hFFFF_FFFC) begin
            bad++;
            $display("FAIL wr_pre pc=%h exp=fffffffc", pc);
        end
        tick();
        total++;
        if (pc !== 32'h0 || inst_pc_o !== 32'hFFFF_FFFC || inst_valid_o !== 1'b1) begin
            bad++;
            $display("FAIL wr_pc pc=%h ip=%h v=%b exp=0/fffffffc/1", pc, inst_pc_o, inst_valid_o);
        end
    endtask

    initial begin
        rst = 1'b1;
        stall_req = '0;
        branch_flag = 1'b0;
        branch_target = '0;
        flush = 1'b0;
        flush_pc = '0;
        test_reset();
        test_wait_states();
        test_stall();
        test_branch();
        test_flush();
        test_wrap();
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule
